alu_arbiter: RTL and testbench

- Shares the single registered ALU between two requesters: port 0 (MIPS core datapath) and port 1 (UART debug/command path).
- Round-robin arbitration; one ALU issue per cycle.
- Per port: valid/ready request handshake and a held response with valid/ready backpressure.
- Sits between the requesters and the ALU instance; drives ALU operands and select, and routes the ALU result back to the issuing port.

---
 rtl/alu_arb_pkg.sv | 44 ++++
 rtl/alu_port_slot.sv | 51 +++++
 rtl/alu_arbiter.sv | 126 ++++++++++++
 tb/tb_alu_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg
//   Shared definitions for the ALU arbiter slice:
//   - ALU op-code constants as seen on pN_op / alu_sel
//   - per-port state encoding (IDLE / WAIT / HOLD)
//   - default operand width
//   - next-state helper for a port slot
package alu_arb_pkg;

  localparam int WIDTH_DEF = 32;

  // ALU select codes. 011, 100 and 101 are not named here; they are
  // forwarded unchanged and the ALU treats them as ADD.
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_AND2 = 3'b110;
  localparam logic [2:0] OP_SLL  = 3'b111;

  // Per-port transaction state
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_HOLD = 2'b10;

  // Next state of one port slot.
  // WAIT always lasts exactly one cycle: that is the cycle in which the
  // registered ALU output belongs to this port.
  // A HOLD -> IDLE handshake never grants in the same cycle because the
  // grant logic only looks at IDLE ports.
  // The unused encoding 11 falls back to IDLE.
  function automatic logic [1:0] slot_next(input logic [1:0] state,
                                           input logic       grant,
                                           input logic       rsp_ready);
    logic [1:0] nxt;
    nxt = ST_IDLE;
    case (state)
      ST_IDLE: nxt = grant ? ST_WAIT : ST_IDLE;
      ST_WAIT: nxt = ST_HOLD;
      ST_HOLD: nxt = rsp_ready ? ST_IDLE : ST_HOLD;
      default: nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/alu_port_slot.sv
// alu_port_slot
//   One requester's transaction tracker: a 2-bit state machine plus the
//   register that holds the ALU result until the requester consumes it.
//
//   Ports:
//     clk        system clock, rising edge
//     rst        asynchronous active-high reset
//     grant      this port was granted the ALU this cycle
//     alu_out    registered ALU result (meaningful only while in WAIT)
//     rsp_ready  requester consumes the held result
//     idle       slot is IDLE (eligible for arbitration)
//     rsp_valid  result held (HOLD)
//     rsp_data   held result
module alu_port_slot
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             grant,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             rsp_ready,
  output logic             idle,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data
);

  logic [1:0]       state;
  logic [WIDTH-1:0] hold;

  // A reset while in WAIT or HOLD simply drops the transaction; the
  // requester never sees a response for it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      hold  <= '0;
    end else begin
      state <= slot_next(state, grant, rsp_ready);
      // The ALU result issued last cycle is on alu_out exactly now.
      if (state == ST_WAIT) begin
        hold <= alu_out;
      end
    end
  end

  assign idle      = (state == ST_IDLE);
  assign rsp_valid = (state == ST_HOLD);
  assign rsp_data  = hold;

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one registered ALU between two requesters (port 0: core
//   datapath, port 1: UART debug path). Round-robin arbitration, one ALU
//   issue per cycle, per-port request handshake and held response.
//
//   Ports:
//     clk, rst                  clock / asynchronous active-high reset
//     pN_req_valid/pN_req_ready request handshake (ready = grant)
//     pN_op, pN_a, pN_b, pN_shamt request fields (sampled in accept cycle)
//     pN_rsp_valid/pN_rsp_ready response handshake
//     pN_rsp_data               held result
//     alu_a, alu_b, alu_sel, alu_shamt  operands to the external ALU
//     alu_out                   registered ALU result (valid cycle after issue)
//     busy                      any port not IDLE
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             p0_req_valid,
  output logic             p0_req_ready,
  input  logic [2:0]       p0_op,
  input  logic [WIDTH-1:0] p0_a,
  input  logic [WIDTH-1:0] p0_b,
  input  logic [4:0]       p0_shamt,
  output logic             p0_rsp_valid,
  input  logic             p0_rsp_ready,
  output logic [WIDTH-1:0] p0_rsp_data,

  input  logic             p1_req_valid,
  output logic             p1_req_ready,
  input  logic [2:0]       p1_op,
  input  logic [WIDTH-1:0] p1_a,
  input  logic [WIDTH-1:0] p1_b,
  input  logic [4:0]       p1_shamt,
  output logic             p1_rsp_valid,
  input  logic             p1_rsp_ready,
  output logic [WIDTH-1:0] p1_rsp_data,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  output logic [4:0]       alu_shamt,
  input  logic [WIDTH-1:0] alu_out,

  output logic             busy
);

  logic idle0, idle1;
  logic elig0, elig1;
  logic grant0, grant1;
  logic last_grant;

  // Arbitration: a tie goes to the port that did not win last time.
  // Depends only on req_valid, slot state and last_grant, never on the
  // request fields.
  assign elig0  = idle0 & p0_req_valid;
  assign elig1  = idle1 & p1_req_valid;
  assign grant0 = elig0 & (~elig1 | last_grant);
  assign grant1 = elig1 & (~elig0 | ~last_grant);

  assign p0_req_ready = grant0;
  assign p1_req_ready = grant1;

  // Resetting to 1 makes port 0 win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (grant0) begin
      last_grant <= 1'b0;
    end else if (grant1) begin
      last_grant <= 1'b1;
    end
  end

  // Issue stage: granted request goes straight to the ALU input; the ALU
  // registers it at the end of this cycle. Idle cycles issue AND 0,0,
  // whose result no slot captures.
  always_comb begin
    alu_a     = '0;
    alu_b     = '0;
    alu_sel   = 3'b000;
    alu_shamt = 5'd0;
    if (grant0) begin
      alu_a     = p0_a;
      alu_b     = p0_b;
      alu_sel   = p0_op;
      alu_shamt = p0_shamt;
    end else if (grant1) begin
      alu_a     = p1_a;
      alu_b     = p1_b;
      alu_sel   = p1_op;
      alu_shamt = p1_shamt;
    end
  end

  // Capture stage: only the slot in WAIT takes alu_out. At most one slot
  // is in WAIT in any cycle since at most one grants per cycle.
  alu_port_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk       (clk),
    .rst       (rst),
    .grant     (grant0),
    .alu_out   (alu_out),
    .rsp_ready (p0_rsp_ready),
    .idle      (idle0),
    .rsp_valid (p0_rsp_valid),
    .rsp_data  (p0_rsp_data)
  );

  alu_port_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .grant     (grant1),
    .alu_out   (alu_out),
    .rsp_ready (p1_rsp_ready),
    .idle      (idle1),
    .rsp_valid (p1_rsp_valid),
    .rsp_data  (p1_rsp_data)
  );

  assign busy = ~idle0 | ~idle1;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Directed bench for alu_arbiter with a behavioural registered ALU and a
//   per-port response scoreboard for the random phase.
module tb_alu_arbiter;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         p0_req_valid, p0_req_ready, p0_rsp_valid, p0_rsp_ready;
  logic [2:0]   p0_op;
  logic [W-1:0] p0_a, p0_b, p0_rsp_data;
  logic [4:0]   p0_shamt;
  logic         p1_req_valid, p1_req_ready, p1_rsp_valid, p1_rsp_ready;
  logic [2:0]   p1_op;
  logic [W-1:0] p1_a, p1_b, p1_rsp_data;
  logic [4:0]   p1_shamt;
  logic [W-1:0] alu_a, alu_b, alu_out;
  logic [2:0]   alu_sel;
  logic [4:0]   alu_shamt;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .p0_req_valid (p0_req_valid),
    .p0_req_ready (p0_req_ready),
    .p0_op        (p0_op),
    .p0_a         (p0_a),
    .p0_b         (p0_b),
    .p0_shamt     (p0_shamt),
    .p0_rsp_valid (p0_rsp_valid),
    .p0_rsp_ready (p0_rsp_ready),
    .p0_rsp_data  (p0_rsp_data),
    .p1_req_valid (p1_req_valid),
    .p1_req_ready (p1_req_ready),
    .p1_op        (p1_op),
    .p1_a         (p1_a),
    .p1_b         (p1_b),
    .p1_shamt     (p1_shamt),
    .p1_rsp_valid (p1_rsp_valid),
    .p1_rsp_ready (p1_rsp_ready),
    .p1_rsp_data  (p1_rsp_data),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_sel      (alu_sel),
    .alu_shamt    (alu_shamt),
    .alu_out      (alu_out),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU behaviour: unknown codes act as ADD, results wrap.
  function automatic logic [W-1:0] alu_f(input logic [2:0] op,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic [4:0] sh);
    case (op)
      3'b000, 3'b110: return a & b;
      3'b001:         return a | b;
      3'b111:         return b << sh;
      default:        return a + b;
    endcase
  endfunction

  // External registered ALU (no reset, like the real one)
  always_ff @(posedge clk) alu_out <= alu_f(alu_sel, alu_a, alu_b, alu_shamt);

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Move to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    cyc();
    rst = 1'b1;
    p0_req_valid = 0; p1_req_valid = 0; p0_rsp_ready = 0; p1_rsp_ready = 0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // One full port-0 transaction with a bounded wait for the response.
  task automatic run_p0(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [4:0] sh, input logic [W-1:0] exp);
    int n;
    cyc();
    p0_req_valid = 1; p0_op = op; p0_a = a; p0_b = b; p0_shamt = sh;
    @(negedge clk);
    chk({tag, "_rdy"}, p0_req_ready, 1);
    chk({tag, "_alu_a"}, alu_a, a);
    chk({tag, "_alu_sel"}, alu_sel, op);
    cyc();
    // Fields only need to be valid in the accept cycle.
    p0_req_valid = 0; p0_a = '0; p0_b = '0; p0_op = 3'b000; p0_shamt = 0;
    n = 0;
    @(negedge clk);
    while (!p0_rsp_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, 1);
    chk({tag, "_data"}, p0_rsp_data, exp);
    p0_rsp_ready = 1;
    cyc();
    p0_rsp_ready = 0;
    @(negedge clk);
    chk({tag, "_done"}, p0_rsp_valid, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  // Scoreboard for the random phase
  logic         sb_en = 1'b0;
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  int           n_acc0 = 0, n_acc1 = 0;

  always @(negedge clk) begin
    if (sb_en) begin
      if (p0_rsp_valid && p0_rsp_ready) begin
        if (q0.size() == 0) chk("sb0_extra", 1, 0);
        else chk("sb0_data", p0_rsp_data, q0.pop_front());
      end
      if (p1_rsp_valid && p1_rsp_ready) begin
        if (q1.size() == 0) chk("sb1_extra", 1, 0);
        else chk("sb1_data", p1_rsp_data, q1.pop_front());
      end
      if (p0_req_ready && p1_req_ready) chk("sb_double_grant", 1, 0);
      if (p0_req_ready) begin
        q0.push_back(alu_f(p0_op, p0_a, p0_b, p0_shamt));
        n_acc0++;
      end
      if (p1_req_ready) begin
        q1.push_back(alu_f(p1_op, p1_a, p1_b, p1_shamt));
        n_acc1++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    p0_req_valid = 0; p0_op = 0; p0_a = 0; p0_b = 0; p0_shamt = 0; p0_rsp_ready = 0;
    p1_req_valid = 0; p1_op = 0; p1_a = 0; p1_b = 0; p1_shamt = 0; p1_rsp_ready = 0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_p0_rsp_valid", p0_rsp_valid, 0);
    chk("rst_p0_rsp_data", p0_rsp_data, 0);
    chk("rst_p1_rsp_valid", p1_rsp_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_sel", alu_sel, 0);
    rst = 1'b0;

    // p0 only: ADD 5+7, response held for 3 cycles under backpressure
    cyc();
    p0_req_valid = 1; p0_op = 3'b010; p0_a = 5; p0_b = 7; p0_shamt = 0;
    @(negedge clk);
    chk("t1_rdy", p0_req_ready, 1);
    cyc();
    p0_req_valid = 0;
    @(negedge clk);
    chk("t1_wait_valid", p0_rsp_valid, 0);
    chk("t1_wait_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      chk("t1_hold_valid", p0_rsp_valid, 1);
      chk("t1_hold_data", p0_rsp_data, 12);
    end
    cyc();
    p0_rsp_ready = 1;
    @(negedge clk);
    chk("t1_hs_valid", p0_rsp_valid, 1);
    cyc();
    p0_rsp_ready = 0;
    @(negedge clk);
    chk("t1_rel_valid", p0_rsp_valid, 0);
    chk("t1_rel_busy", busy, 0);

    // Simultaneous requests after reset: p0 first, p1 next cycle
    reset_dut();
    p0_req_valid = 1; p0_op = 3'b001; p0_a = 32'hF0; p0_b = 32'h0F; p0_shamt = 0;
    p1_req_valid = 1; p1_op = 3'b111; p1_a = 0; p1_b = 1; p1_shamt = 4;
    @(negedge clk);
    chk("t2_tie_p0", p0_req_ready, 1);
    chk("t2_tie_p1", p1_req_ready, 0);
    cyc();
    p0_req_valid = 0;
    @(negedge clk);
    chk("t2_p1_rdy", p1_req_ready, 1);
    chk("t2_p1_sel", alu_sel, 3'b111);
    cyc();
    p1_req_valid = 0; p0_rsp_ready = 1;
    @(negedge clk);
    chk("t2_p0_valid", p0_rsp_valid, 1);
    chk("t2_p0_data", p0_rsp_data, 32'hFF);
    chk("t2_p1_notyet", p1_rsp_valid, 0);
    cyc();
    p0_rsp_ready = 0; p1_rsp_ready = 1;
    @(negedge clk);
    chk("t2_p1_valid", p1_rsp_valid, 1);
    chk("t2_p1_data", p1_rsp_data, 32'h10);
    chk("t2_p0_gone", p0_rsp_valid, 0);
    cyc();
    p1_rsp_ready = 0;
    p0_req_valid = 1; p0_op = 3'b010; p0_a = 1; p0_b = 1;
    p1_req_valid = 1; p1_op = 3'b010; p1_a = 2; p1_b = 2;
    @(negedge clk);
    chk("t2_tie2_p0", p0_req_ready, 1);
    chk("t2_tie2_p1", p1_req_ready, 0);
    cyc();
    p0_req_valid = 0;
    cyc();
    p1_req_valid = 0; p0_rsp_ready = 1; p1_rsp_ready = 1;
    repeat (5) cyc();
    p0_rsp_ready = 0; p1_rsp_ready = 0;
    @(negedge clk);
    chk("t2_drain_busy", busy, 0);

    // p1 withheld while p0 issues ADD with wrap-around
    cyc();
    p1_req_valid = 1; p1_op = 3'b010; p1_a = 1; p1_b = 1; p1_shamt = 0;
    @(negedge clk);
    chk("t3_p1_rdy", p1_req_ready, 1);
    cyc();
    p0_req_valid = 1; p0_op = 3'b010; p0_a = 32'hFFFF_FFFF; p0_b = 1; p0_shamt = 0;
    p0_rsp_ready = 1;
    @(negedge clk);
    chk("t3_p0_rdy", p0_req_ready, 1);
    chk("t3_p1_blocked0", p1_req_ready, 0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      p0_req_valid = 0;
      @(negedge clk);
      chk("t3_p1_blocked", p1_req_ready, 0);
      chk("t3_p1_held", p1_rsp_valid, 1);
      chk("t3_p1_data", p1_rsp_data, 2);
      if (i == 1) begin
        chk("t3_p0_valid", p0_rsp_valid, 1);
        chk("t3_p0_wrap", p0_rsp_data, 0);
      end
    end
    cyc();
    p0_rsp_ready = 0; p1_req_valid = 0; p1_rsp_ready = 1;
    cyc();
    p1_rsp_ready = 0;
    @(negedge clk);
    chk("t3_busy", busy, 0);

    // Undefined op code behaves as ADD
    run_p0("t4_op101", 3'b101, 3, 4, 0, 7);

    // Async reset while p0 is in WAIT
    cyc();
    p0_req_valid = 1; p0_op = 3'b010; p0_a = 2; p0_b = 3;
    @(negedge clk);
    chk("t5_rdy", p0_req_ready, 1);
    cyc();
    p0_req_valid = 0;
    #2 rst = 1'b1;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_rsp_valid", p0_rsp_valid, 0);
    chk("t5_rsp_data", p0_rsp_data, 0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_no_rsp", p0_rsp_valid, 0);
      chk("t5_idle", busy, 0);
    end
    run_p0("t5_fresh", 3'b010, 10, 20, 0, 30);

    // Random traffic on both ports against the scoreboard
    sb_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc();
      p0_req_valid = ($urandom_range(0, 3) != 0);
      p0_op = 3'($urandom_range(0, 7)); p0_a = $urandom; p0_b = $urandom;
      p0_shamt = 5'($urandom_range(0, 31)); p0_rsp_ready = 1'($urandom_range(0, 1));
      p1_req_valid = ($urandom_range(0, 3) != 0);
      p1_op = 3'($urandom_range(0, 7)); p1_a = $urandom; p1_b = $urandom;
      p1_shamt = 5'($urandom_range(0, 31)); p1_rsp_ready = 1'($urandom_range(0, 1));
    end
    cyc();
    p0_req_valid = 0; p1_req_valid = 0; p0_rsp_ready = 1; p1_rsp_ready = 1;
    repeat (6) cyc();
    sb_en = 1'b0;
    p0_rsp_ready = 0; p1_rsp_ready = 0;
    chk("sb0_lost", q0.size(), 0);
    chk("sb1_lost", q1.size(), 0);
    chk("sb0_traffic", (n_acc0 > 10), 1);
    chk("sb1_traffic", (n_acc1 > 10), 1);
    @(negedge clk);
    chk("sb_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
